// File: rtl/frame_fade_sub.sv
// Streaming saturating-subtract fader for RGB444 pixels with a frame-stepped fade ramp.
// One register stage; the fade level latches on accepted start-of-frame pixels.
module frame_fade_sub #(
  parameter int FRAMES_PER_STEP = 4,
  parameter int STEP            = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sof,
  input  logic [11:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sof,
  output logic [11:0] out_data,
  output logic [3:0]  level,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(FRAMES_PER_STEP + 1);
  localparam logic [CW-1:0] FPS_C  = CW'(FRAMES_PER_STEP);
  localparam logic [4:0]    STEP_C = 5'(STEP);

  typedef enum logic [1:0] {IDLE, FADING, HOLD} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    level_reg, level_next;
  logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
  logic          done_reg, done_next;
  logic          out_valid_reg, out_sof_reg;
  logic [11:0]   out_data_reg, faded;
  logic [4:0]    level_sum;
  logic          accept;

  assign in_ready  = !out_valid_reg || out_ready;
  assign accept    = in_valid && in_ready;
  assign cnt_inc   = cnt_reg + CW'(1);
  assign level_sum = {1'b0, level_reg} + STEP_C;

  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    if (start) begin
      // A restart also overrides an sof accepted in the same cycle.
      state_next = FADING;
      level_next = 4'h0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: level_next = 4'h0;
        FADING: begin
          if (accept && in_sof) begin
            if (cnt_inc == FPS_C) begin
              cnt_next   = '0;
              level_next = (level_sum > 5'd15) ? 4'hF : level_sum[3:0];
              if (level_next == 4'hF) begin
                state_next = HOLD;
                done_next  = 1'b1;
              end
            end else begin
              cnt_next = cnt_inc;
            end
          end
        end
        HOLD: level_next = 4'hF;
        default: begin
          state_next = IDLE;
          level_next = 4'h0;
        end
      endcase
    end
  end

  // Pixels are faded with the level in effect after this cycle's update,
  // so an sof pixel that bumps the level already uses the new value.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      logic [3:0] chan;
      assign chan = in_data[gi*4 +: 4];
      assign faded[gi*4 +: 4] = (chan > level_next) ? (chan - level_next) : 4'h0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      level_reg <= 4'h0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      level_reg <= level_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_sof_reg   <= 1'b0;
      out_data_reg  <= 12'h000;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_sof_reg   <= in_sof;
      out_data_reg  <= faded;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_sof   = out_sof_reg;
  assign out_data  = out_data_reg;
  assign level     = level_reg;
  assign busy      = (state_reg == FADING);
  assign done      = done_reg;

endmodule

// File: tb/tb_frame_fade_sub.sv
// Randomized self-checking bench for frame_fade_sub against a per-frame fade reference model.
module tb_frame_fade_sub;

  localparam int FPS  = 2;
  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sof = 1'b0;
  logic [11:0] in_data = 12'h000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sof;
  logic [11:0] out_data;
  logic [3:0]  level;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state: 0 idle, 1 fading, 2 hold
  int          m_state = 0;
  int          m_level = 0;
  int          m_cnt   = 0;
  logic        m_valid = 1'b0;
  logic        m_sof   = 1'b0;
  logic [11:0] m_data  = 12'h000;
  logic        m_done  = 1'b0;

  frame_fade_sub #(.FRAMES_PER_STEP(FPS), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_data(out_data),
    .level(level), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [11:0] fade_ref(input logic [11:0] px, input int lvl);
    int res = 0;
    for (int ch = 0; ch < 3; ch++) begin
      int c = (int'(px) >> (4 * ch)) & 15;
      int r = c - lvl;
      if (r < 0) r = 0;
      res = res | (r << (4 * ch));
    end
    return 12'(res);
  endfunction

  // Drives one cycle of inputs, advances the model, returns at posedge+1.
  task automatic tick(input logic st, input logic iv, input logic isof,
                      input logic [11:0] d, input logic ordy);
    logic acc;
    start = st; in_valid = iv; in_sof = isof; in_data = d; out_ready = ordy;
    acc = iv && (!m_valid || ordy);
    m_done = 1'b0;
    if (st) begin
      m_state = 1; m_level = 0; m_cnt = 0;
    end else if (acc && isof && m_state == 1) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == FPS) begin
        m_cnt = 0;
        m_level = (m_level + STEP > 15) ? 15 : m_level + STEP;
        if (m_level == 15) begin
          m_state = 2;
          m_done = 1'b1;
        end
      end
    end
    if (acc) begin
      m_valid = 1'b1; m_data = fade_ref(d, m_level); m_sof = isof;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    start = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic do_reset();
    start = 0; in_valid = 0; in_sof = 0; in_data = 0; out_ready = 1;
    rst = 1'b1;
    m_state = 0; m_level = 0; m_cnt = 0; m_valid = 0; m_sof = 0; m_data = 0; m_done = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_sof !== 1'b0) $display("FAIL reset_sof got %b want 0", out_sof); else n_pass++;
    n_checks++; if (out_data !== 12'h000) $display("FAIL reset_data got %h want 000", out_data); else n_pass++;
    n_checks++; if (level !== 4'h0) $display("FAIL reset_level got %h want 0", level); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", in_ready); else n_pass++;
    $display("reset: checked idle outputs");
  endtask

  task automatic test_passthrough();
    tick(0, 1, 1, 12'hA5F, 1);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL pass_valid got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== 12'hA5F) $display("FAIL pass_data got %h want A5F", out_data); else n_pass++;
    n_checks++; if (out_sof !== 1'b1) $display("FAIL pass_sof got %b want 1", out_sof); else n_pass++;
    $display("passthrough: in A5F out %h", out_data);
    for (int i = 0; i < 8; i++) begin
      logic [11:0] d = 12'($urandom);
      logic s = 1'($urandom_range(0, 1));
      tick(0, 1, s, d, 1);
      n_checks++; if (out_data !== d) $display("FAIL pass_rnd got %h want %h", out_data, d); else n_pass++;
      n_checks++; if (level !== 4'h0 || busy !== 1'b0) $display("FAIL pass_idle level %h busy %b want 0 0", level, busy); else n_pass++;
      $display("passthrough: sof %b in %h out %h", s, d, out_data);
    end
  endtask

  task automatic test_saturation();
    logic [11:0] px [3];
    logic [11:0] want [3];
    px[0] = 12'h4A2; px[1] = 12'hFFF; px[2] = 12'h123;
    want[0] = 12'h060; want[1] = 12'hBBB; want[2] = 12'h000;
    tick(1, 0, 0, 12'h000, 1);
    tick(0, 1, 1, 12'h777, 1);
    tick(0, 1, 1, 12'h777, 1);
    n_checks++; if (level !== 4'h4) $display("FAIL sat_level got %h want 4", level); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, px[i], 1);
      n_checks++; if (out_data !== want[i]) $display("FAIL sat_data in %h got %h want %h", px[i], out_data, want[i]); else n_pass++;
      n_checks++; if (out_data !== m_data) $display("FAIL sat_model in %h got %h want %h", px[i], out_data, m_data); else n_pass++;
      $display("saturation: level %0d in %h out %h", level, px[i], out_data);
    end
  endtask

  task automatic test_ramp();
    int exp_lv [8] = '{0, 4, 4, 8, 8, 12, 12, 15};
    int done_cnt = 0;
    tick(1, 0, 0, 12'h000, 1);
    n_checks++; if (busy !== 1'b1 || level !== 4'h0) $display("FAIL ramp_start busy %b level %h want 1 0", busy, level); else n_pass++;
    for (int f = 0; f < 10; f++) begin
      for (int p = 0; p < 2; p++) begin
        logic [11:0] d = 12'($urandom);
        tick(0, 1, (p == 0), d, 1);
        if (done === 1'b1) done_cnt++;
        n_checks++; if (level !== 4'(m_level)) $display("FAIL ramp_level got %h want %h", level, 4'(m_level)); else n_pass++;
        n_checks++; if (out_data !== m_data) $display("FAIL ramp_data in %h got %h want %h", d, out_data, m_data); else n_pass++;
        n_checks++; if (done !== m_done) $display("FAIL ramp_done got %b want %b", done, m_done); else n_pass++;
        if (p == 0 && f < 8) begin
          n_checks++; if (level !== 4'(exp_lv[f])) $display("FAIL ramp_step frame %0d got %0d want %0d", f, level, exp_lv[f]); else n_pass++;
        end
        $display("ramp: frame %0d pix %0d level %0d done %b busy %b", f, p, level, done, busy);
      end
    end
    n_checks++; if (done_cnt != 1) $display("FAIL ramp_done_count got %0d want 1", done_cnt); else n_pass++;
    n_checks++; if (busy !== 1'b0 || level !== 4'hF) $display("FAIL ramp_hold busy %b level %h want 0 F", busy, level); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [11:0] held;
    tick(1, 0, 0, 12'h000, 1);
    tick(0, 1, 1, 12'h9C3, 1);
    held = out_data;
    n_checks++; if (held !== 12'h9C3) $display("FAIL bp_first got %h want 9C3", held); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_sof = 1; out_ready = 0;
      #1;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready got %b want 0", in_ready); else n_pass++;
      tick(0, 1, 1, 12'($urandom), 0);
      n_checks++; if (out_valid !== 1'b1 || out_data !== held) $display("FAIL bp_hold got %b/%h want 1/%h", out_valid, out_data, held); else n_pass++;
      n_checks++; if (level !== 4'h0) $display("FAIL bp_level got %h want 0", level); else n_pass++;
      $display("backpressure: stall %0d out %h level %0d", i, out_data, level);
    end
    tick(0, 0, 0, 12'h000, 1);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_drain got %b want 0", out_valid); else n_pass++;
    tick(0, 1, 1, 12'hFFF, 1);
    n_checks++; if (level !== 4'h4 || out_data !== 12'hBBB) $display("FAIL bp_resume level %h data %h want 4 BBB", level, out_data); else n_pass++;
    $display("backpressure: resume level %0d out %h", level, out_data);
  endtask

  task automatic test_restart();
    tick(1, 0, 0, 12'h000, 1);
    for (int f = 0; f < 4; f++) begin
      tick(0, 1, 1, 12'($urandom), 1);
      tick(0, 1, 0, 12'($urandom), 1);
    end
    n_checks++; if (level !== 4'h8) $display("FAIL rs_pre got %h want 8", level); else n_pass++;
    tick(1, 1, 0, 12'h5A5, 1);
    n_checks++; if (level !== 4'h0 || busy !== 1'b1 || done !== 1'b0) $display("FAIL rs_restart level %h busy %b done %b want 0 1 0", level, busy, done); else n_pass++;
    n_checks++; if (out_data !== 12'h5A5) $display("FAIL rs_data got %h want 5A5", out_data); else n_pass++;
    tick(0, 1, 1, 12'h888, 1);
    n_checks++; if (level !== 4'h0) $display("FAIL rs_cnt1 got %h want 0", level); else n_pass++;
    tick(0, 1, 1, 12'h888, 1);
    n_checks++; if (level !== 4'h4 || out_data !== 12'h444) $display("FAIL rs_cnt2 level %h data %h want 4 444", level, out_data); else n_pass++;
    $display("restart: level %0d out %h", level, out_data);
  endtask

  task automatic test_rst_mid();
    tick(0, 1, 0, 12'h321, 0);
    tick(0, 1, 0, 12'h654, 0);
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL arst_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (level !== 4'h0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL arst_state level %h busy %b done %b want 0 0 0", level, busy, done); else n_pass++;
    m_state = 0; m_level = 0; m_cnt = 0; m_valid = 0; m_sof = 0; m_data = 0; m_done = 0;
    @(negedge clk);
    rst = 1'b0;
    tick(0, 1, 1, 12'hCDE, 1);
    n_checks++; if (out_data !== 12'hCDE || out_valid !== 1'b1 || busy !== 1'b0) $display("FAIL arst_resume data %h valid %b busy %b want CDE 1 0", out_data, out_valid, busy); else n_pass++;
    $display("reset mid-stream: resumed out %h", out_data);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic st = ($urandom_range(0, 59) == 0);
      logic iv = ($urandom_range(0, 3) != 0);
      logic sf = ($urandom_range(0, 4) == 0);
      logic rd = ($urandom_range(0, 2) != 0);
      logic [11:0] d = 12'($urandom);
      tick(st, iv, sf, d, rd);
      n_checks++; if (out_valid !== m_valid) $display("FAIL rnd_valid cyc %0d got %b want %b", i, out_valid, m_valid); else n_pass++;
      if (m_valid) begin
        n_checks++; if (out_data !== m_data || out_sof !== m_sof) $display("FAIL rnd_data cyc %0d got %h/%b want %h/%b", i, out_data, out_sof, m_data, m_sof); else n_pass++;
      end
      n_checks++; if (level !== 4'(m_level)) $display("FAIL rnd_level cyc %0d got %h want %h", i, level, 4'(m_level)); else n_pass++;
      n_checks++; if (busy !== (m_state == 1) || done !== m_done) $display("FAIL rnd_ctl cyc %0d busy %b done %b want %b %b", i, busy, done, (m_state == 1), m_done); else n_pass++;
      $display("random: cyc %0d st %b acc-in %b sof %b out %b/%h level %0d", i, st, iv, sf, out_valid, out_data, level);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_saturation();
    test_ramp();
    test_backpressure();
    test_restart();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
